ysyx_22050612_rf_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters, EXU (ALU/CSR results) and LSU (load data).
- Drives the register file's wen/waddr/wdata from a registered output stage.
- Keeps a per-register busy scoreboard so decode can stall on pending writes.
- Sits between the EXU/LSU writeback paths and ysyx_22050612_RegisterFile.

---
 rtl/ysyx_22050612_rf_wb_arbiter_if.sv | 63 ++++++
 rtl/ysyx_22050612_rf_wb_arbiter.sv | 104 ++++++++++
 tb/tb_ysyx_22050612_rf_wb_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050612_rf_wb_arbiter_if.sv
// Writeback bus between the EXU/LSU requesters, decode and the shared register-file write port.
// Forwarding signals exist only when YSYX_22050612_WB_FWD_EN is defined.
interface ysyx_22050612_rf_wb_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned NumRegs = 1 << ADDR_WIDTH;

  logic                  exu_valid;
  logic                  exu_ready;
  logic [ADDR_WIDTH-1:0] exu_rd;
  logic [DATA_WIDTH-1:0] exu_data;
  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;
  logic                  alloc_en;
  logic [ADDR_WIDTH-1:0] alloc_rd;
  logic [NumRegs-1:0]    busy;
  logic                  idle;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
`ifdef YSYX_22050612_WB_FWD_EN
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic                  fwd1_hit;
  logic                  fwd2_hit;
  logic [DATA_WIDTH-1:0] fwd1_data;
  logic [DATA_WIDTH-1:0] fwd2_data;
`endif

  // Arbiter side.
  modport slave (
    input  exu_valid, exu_rd, exu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  alloc_en, alloc_rd,
    output exu_ready, lsu_ready,
    output busy, idle,
    output rf_wen, rf_waddr, rf_wdata
`ifdef YSYX_22050612_WB_FWD_EN
    ,
    input  rs1, rs2,
    output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
`endif
  );

  // Requester / decode side.
  modport master (
    output exu_valid, exu_rd, exu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output alloc_en, alloc_rd,
    input  exu_ready, lsu_ready,
    input  busy, idle,
    input  rf_wen, rf_waddr, rf_wdata
`ifdef YSYX_22050612_WB_FWD_EN
    ,
    output rs1, rs2,
    input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
`endif
  );

endinterface

// File: rtl/ysyx_22050612_rf_wb_arbiter.sv
// Round-robin EXU/LSU arbiter for the single register-file write port, with a busy scoreboard.
// Optional decode bypass of the in-flight write under YSYX_22050612_WB_FWD_EN.
module ysyx_22050612_rf_wb_arbiter #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic                         clk,
  input logic                         rst,
  ysyx_22050612_rf_wb_arbiter_if.slave wb
);
  localparam int unsigned NumRegs = 1 << ADDR_WIDTH;

  typedef enum logic {GrantExu, GrantLsu} grant_e;

  grant_e                last_grant_q, last_grant_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [NumRegs-1:0]    busy_q, busy_d;

  logic                  grant_exu, grant_lsu, xfer;
  logic [ADDR_WIDTH-1:0] win_rd;
  logic [DATA_WIDTH-1:0] win_data;
  logic [NumRegs-1:0]    clr_vec, set_vec;

  // Ties go to whoever did not win last; nothing is granted while in reset.
  always_comb begin
    grant_exu = 1'b0;
    grant_lsu = 1'b0;
    if (!rst) begin
      if (wb.exu_valid && wb.lsu_valid) begin
        if (last_grant_q == GrantLsu) grant_exu = 1'b1;
        else                          grant_lsu = 1'b1;
      end else begin
        grant_exu = wb.exu_valid;
        grant_lsu = wb.lsu_valid;
      end
    end
  end

  assign xfer     = grant_exu | grant_lsu;
  assign win_rd   = grant_lsu ? wb.lsu_rd   : wb.exu_rd;
  assign win_data = grant_lsu ? wb.lsu_data : wb.exu_data;

  always_comb begin
    last_grant_d = last_grant_q;
    rf_wen_d     = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    clr_vec      = '0;
    set_vec      = '0;

    if (grant_lsu)      last_grant_d = GrantLsu;
    else if (grant_exu) last_grant_d = GrantExu;

    // x0 writes are consumed but never reach the register file.
    if (xfer && (win_rd != '0)) begin
      rf_wen_d         = 1'b1;
      rf_waddr_d       = win_rd;
      rf_wdata_d       = win_data;
      clr_vec[win_rd]  = 1'b1;
    end

    if (wb.alloc_en && (wb.alloc_rd != '0)) begin
      set_vec[wb.alloc_rd] = 1'b1;
    end

    // Set after clear: a fresh allocation outranks the retiring older producer.
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GrantLsu;
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_wen_q     <= rf_wen_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign wb.exu_ready = grant_exu;
  assign wb.lsu_ready = grant_lsu;
  assign wb.busy      = busy_q;
  assign wb.idle      = (busy_q == '0) && !rf_wen_q;
  assign wb.rf_wen    = rf_wen_q;
  assign wb.rf_waddr  = rf_waddr_q;
  assign wb.rf_wdata  = rf_wdata_q;

`ifdef YSYX_22050612_WB_FWD_EN
  assign wb.fwd1_hit  = rf_wen_q && (rf_waddr_q == wb.rs1) && (wb.rs1 != '0);
  assign wb.fwd2_hit  = rf_wen_q && (rf_waddr_q == wb.rs2) && (wb.rs2 != '0);
  assign wb.fwd1_data = rf_wdata_q;
  assign wb.fwd2_data = rf_wdata_q;
`endif

endmodule

// File: tb/tb_ysyx_22050612_rf_wb_arbiter.sv
// Scoreboard bench: stimulus queues expected register-file writes, a monitor retires them.
module tb_ysyx_22050612_rf_wb_arbiter;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  wr_t  exp_q[$];

  ysyx_22050612_rf_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb ();

  ysyx_22050612_rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Outputs are registered, so sampling at negedge sees the result of the preceding posedge.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (wb.rf_wen === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", 64'(wb.rf_waddr), 64'hFFFF);
        end else begin
          w = exp_q.pop_front();
          check("write_addr", 64'(wb.rf_waddr), 64'(w.addr));
          check("write_data", 64'(wb.rf_wdata), 64'(w.data));
        end
      end
    end
  end

  task automatic clear_inputs();
    wb.exu_valid = 1'b0; wb.exu_rd = '0; wb.exu_data = '0;
    wb.lsu_valid = 1'b0; wb.lsu_rd = '0; wb.lsu_data = '0;
    wb.alloc_en  = 1'b0; wb.alloc_rd = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clear_inputs();
`ifdef YSYX_22050612_WB_FWD_EN
    wb.rs1 = '0;
    wb.rs2 = '0;
`endif
    do_reset();
    check("reset_rf_wen", 64'(wb.rf_wen), 64'd0);
    check("reset_rf_waddr", 64'(wb.rf_waddr), 64'd0);
    check("reset_rf_wdata", 64'(wb.rf_wdata), 64'd0);
    check("reset_busy", 64'(wb.busy), 64'd0);
    check("reset_idle", 64'(wb.idle), 64'd1);

    // Single EXU write to r5.
    wb.exu_valid = 1'b1; wb.exu_rd = 5'd5; wb.exu_data = 32'h1234;
    #1;
    check("single_exu_ready", 64'(wb.exu_ready), 64'd1);
    check("single_lsu_ready", 64'(wb.lsu_ready), 64'd0);
    push(5'd5, 32'h1234);
    step();
    wb.exu_valid = 1'b0;
    check("single_not_idle", 64'(wb.idle), 64'd0);
    step();
    check("single_wen_drop", 64'(wb.rf_wen), 64'd0);

    // Fresh reset, then a two-way tie: EXU first, LSU next.
    do_reset();
    wb.exu_valid = 1'b1; wb.exu_rd = 5'd1; wb.exu_data = 32'hA;
    wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd2; wb.lsu_data = 32'hB;
    #1;
    check("tie1_exu_ready", 64'(wb.exu_ready), 64'd1);
    check("tie1_lsu_ready", 64'(wb.lsu_ready), 64'd0);
    push(5'd1, 32'hA);
    step();
    wb.exu_valid = 1'b0;
    #1;
    check("tie2_lsu_ready", 64'(wb.lsu_ready), 64'd1);
    push(5'd2, 32'hB);
    step();
    wb.lsu_valid = 1'b0;
    step();

    // Allocate r7, hold three cycles, LSU retires it.
    wb.alloc_en = 1'b1; wb.alloc_rd = 5'd7;
    step();
    wb.alloc_en = 1'b0;
    check("alloc7_busy_c1", 64'(wb.busy), 64'h80);
    check("alloc7_not_idle", 64'(wb.idle), 64'd0);
    step();
    check("alloc7_busy_c2", 64'(wb.busy), 64'h80);
    step();
    check("alloc7_busy_c3", 64'(wb.busy), 64'h80);
    wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd7; wb.lsu_data = 32'h77;
    #1;
    check("lsu7_ready", 64'(wb.lsu_ready), 64'd1);
    push(5'd7, 32'h77);
    step();
    wb.lsu_valid = 1'b0;
    check("lsu7_busy_clear", 64'(wb.busy), 64'd0);
    check("lsu7_wen", 64'(wb.rf_wen), 64'd1);
    check("lsu7_not_idle", 64'(wb.idle), 64'd0);
    step();
    check("lsu7_idle_after", 64'(wb.idle), 64'd1);

    // Set and clear of r9 on the same edge: set wins.
    wb.alloc_en = 1'b1; wb.alloc_rd = 5'd9;
    step();
    check("alloc9_busy", 64'(wb.busy), 64'h200);
    wb.exu_valid = 1'b1; wb.exu_rd = 5'd9; wb.exu_data = 32'h99;
    #1;
    check("exu9_ready", 64'(wb.exu_ready), 64'd1);
    push(5'd9, 32'h99);
    step();
    wb.alloc_en = 1'b0; wb.exu_valid = 1'b0;
    check("same_edge_busy9", 64'(wb.busy), 64'h200);
    wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd9; wb.lsu_data = 32'h9A;
    #1;
    check("lsu9_ready", 64'(wb.lsu_ready), 64'd1);
    push(5'd9, 32'h9A);
    step();
    wb.lsu_valid = 1'b0;
    check("lsu9_busy_clear", 64'(wb.busy), 64'd0);

    // x0 write plus x0 allocation: accepted, no write, no busy.
    wb.exu_valid = 1'b1; wb.exu_rd = 5'd0; wb.exu_data = 32'hFFFF;
    wb.alloc_en  = 1'b1; wb.alloc_rd = 5'd0;
    #1;
    check("x0_exu_ready", 64'(wb.exu_ready), 64'd1);
    step();
    clear_inputs();
    check("x0_no_wen", 64'(wb.rf_wen), 64'd0);
    check("x0_busy", 64'(wb.busy), 64'd0);
    check("x0_idle", 64'(wb.idle), 64'd1);

    // x0 transfer counted as an EXU grant, so this tie goes to LSU.
    wb.exu_valid = 1'b1; wb.exu_rd = 5'd3; wb.exu_data = 32'h33;
    wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd4; wb.lsu_data = 32'h44;
    #1;
    check("rr_lsu_ready", 64'(wb.lsu_ready), 64'd1);
    check("rr_exu_wait", 64'(wb.exu_ready), 64'd0);
    push(5'd4, 32'h44);
    step();
    wb.lsu_valid = 1'b0;
    #1;
    check("rr_exu_ready", 64'(wb.exu_ready), 64'd1);
    push(5'd3, 32'h33);
    step();
    wb.exu_valid = 1'b0;
    step();

    // Build busy=0x84, then reset with both requesters pending.
    wb.alloc_en = 1'b1; wb.alloc_rd = 5'd2;
    step();
    wb.alloc_rd = 5'd7;
    step();
    wb.alloc_en = 1'b0; wb.alloc_rd = 5'd0;
    check("pre_reset_busy", 64'(wb.busy), 64'h84);
    rst = 1'b1;
    wb.exu_valid = 1'b1; wb.exu_rd = 5'd10; wb.exu_data = 32'hAA;
    wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd11; wb.lsu_data = 32'hBB;
    #1;
    check("rst_exu_ready", 64'(wb.exu_ready), 64'd0);
    check("rst_lsu_ready", 64'(wb.lsu_ready), 64'd0);
    step();
    #1;
    check("rst2_exu_ready", 64'(wb.exu_ready), 64'd0);
    check("rst2_lsu_ready", 64'(wb.lsu_ready), 64'd0);
    step();
    rst = 1'b0;
    #1;
    check("post_rst_busy", 64'(wb.busy), 64'd0);
    check("post_rst_wen", 64'(wb.rf_wen), 64'd0);
    check("post_rst_exu_ready", 64'(wb.exu_ready), 64'd1);
    check("post_rst_lsu_wait", 64'(wb.lsu_ready), 64'd0);
    push(5'd10, 32'hAA);
    step();
    wb.exu_valid = 1'b0;
    #1;
    check("post_rst_lsu_ready", 64'(wb.lsu_ready), 64'd1);
    push(5'd11, 32'hBB);
    step();
    wb.lsu_valid = 1'b0;
    step();
    step();

    check("writes_outstanding", 64'(exp_q.size()), 64'd0);
    check("final_idle", 64'(wb.idle), 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
